// File: rtl/fpmult_round_arbiter_if.sv
// Handshake bundle between the two multiplier pipelines, the shared
// normalize/round stage and the downstream pack stage.
interface fpmult_round_arbiter_if #(
   parameter int MANT_W = 10,
   parameter int EXP_W  = 5
);
   logic              req0_valid;
   logic              req0_ready;
   logic [MANT_W-1:0] req0_m;
   logic [EXP_W:0]    req0_e;
   logic              req0_rnd;

   logic              req1_valid;
   logic              req1_ready;
   logic [MANT_W-1:0] req1_m;
   logic [EXP_W:0]    req1_e;
   logic              req1_rnd;

   logic              out_valid;
   logic              out_ready;
   logic [MANT_W:0]   out_m;
   logic [EXP_W:0]    out_e;
   logic              out_id;
   logic              out_uf;
   logic              busy;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_m, req0_e, req0_rnd,
      input  req1_valid, req1_m, req1_e, req1_rnd,
      input  out_ready,
      output req0_ready, req1_ready,
      output out_valid, out_m, out_e, out_id, out_uf, busy
   );

   // Environment side (requesters plus downstream consumer)
   modport master (
      output req0_valid, req0_m, req0_e, req0_rnd,
      output req1_valid, req1_m, req1_e, req1_rnd,
      output out_ready,
      input  req0_ready, req1_ready,
      input  out_valid, out_m, out_e, out_id, out_uf, busy
   );
endinterface

// File: rtl/fpmult_round_arbiter.sv
// Round-robin arbiter and two-stage pipeline for the shared FP multiplier
// normalize/round stage: grant, unbias, round increment and exponent bump.
module fpmult_round_arbiter #(
   parameter int MANT_W = 10,
   parameter int EXP_W  = 5,
   parameter int BIAS   = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   fpmult_round_arbiter_if.slave bus
);

   localparam logic [EXP_W:0] BIAS_E = (EXP_W+1)'(BIAS);
   localparam logic [EXP_W:0] ONE_E  = {{EXP_W{1'b0}}, 1'b1};

   logic              prio;
   logic              grant;
   logic              accept;
   logic              s1Adv;
   logic              s2Adv;

   logic              s1Valid;
   logic              s1Id;
   logic              s1Rnd;
   logic [MANT_W-1:0] s1M;
   logic [EXP_W:0]    s1E;
   logic              s2Valid;

   logic [MANT_W:0]   sum;
   logic              carry;
   logic [EXP_W:0]    roundE;
   logic [EXP_W:0]    roundEP;
   logic              uf;

   // Grant selection and pipeline advance; grant is a pure function of the
   // held requests and prio, so it stays put while the pipe is stalled.
   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant = prio;
      end else if (bus.req1_valid) begin
         grant = 1'b1;
      end else begin
         grant = 1'b0;
      end
      s2Adv = !s2Valid || bus.out_ready;
      s1Adv = !s1Valid || s2Adv;
   end

   // Ready goes only to the granted requester, and never during reset
   always_comb begin
      bus.req0_ready = rst && s1Adv && !grant;
      bus.req1_ready = rst && s1Adv && grant;
      accept = (bus.req0_valid && bus.req0_ready) ||
               (bus.req1_valid && bus.req1_ready);
   end

   // Round increment, unbias and renormalizing bump computed from S1
   always_comb begin
      sum     = {1'b0, s1M} + {{MANT_W{1'b0}}, s1Rnd};
      carry   = sum[MANT_W];
      roundE  = s1E - BIAS_E;
      roundEP = s1E - BIAS_E + ONE_E;
      if (carry) begin
         uf = (s1E < (BIAS_E - ONE_E));
      end else begin
         uf = (s1E < BIAS_E);
      end
   end

   // Pipeline registers, output register and round-robin pointer
   always_ff @(posedge clk) begin
      if (!rst) begin
         prio        <= 1'b0;
         s1Valid     <= 1'b0;
         s1Id        <= 1'b0;
         s1Rnd       <= 1'b0;
         s1M         <= '0;
         s1E         <= '0;
         s2Valid     <= 1'b0;
         bus.out_m   <= '0;
         bus.out_e   <= '0;
         bus.out_id  <= 1'b0;
         bus.out_uf  <= 1'b0;
      end else begin
         if (accept) begin
            prio <= ~grant;
         end
         if (s1Adv) begin
            s1Valid <= accept;
            s1Id    <= grant;
            s1M     <= grant ? bus.req1_m   : bus.req0_m;
            s1E     <= grant ? bus.req1_e   : bus.req0_e;
            s1Rnd   <= grant ? bus.req1_rnd : bus.req0_rnd;
         end
         if (s2Adv) begin
            s2Valid    <= s1Valid;
            bus.out_m  <= sum;
            bus.out_e  <= carry ? roundEP : roundE;
            bus.out_id <= s1Id;
            bus.out_uf <= uf;
         end
      end
   end

   assign bus.out_valid = s2Valid;
   assign bus.busy      = s1Valid || s2Valid;

endmodule

// File: tb/tb_fpmult_round_arbiter.sv
// Self-checking bench: directed plan steps plus random traffic, checked
// against a queue-based reference model of the arbiter and round stage.
module tb_fpmult_round_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fpmult_round_arbiter_if bus ();

   fpmult_round_arbiter dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int m;
      int e;
      int rnd;
   } op_t;

   typedef struct {
      logic [10:0] m;
      logic [5:0]  e;
      logic        id;
      logic        uf;
      logic        vis;
   } res_t;

   op_t  src0[$];
   op_t  src1[$];
   res_t q[$];
   res_t dq[$];
   logic outReady = 1'b0;
   logic prio = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   accCnt = 0;

   // Reference: plain integer arithmetic on the unbiased exponent
   function automatic res_t model(op_t o, logic id);
      res_t r;
      int s, c, ea;
      s  = o.m + o.rnd;
      c  = (s >= 1024) ? 1 : 0;
      ea = o.e - 15 + c;
      r.m   = 11'(s);
      r.e   = 6'((ea + 64) % 64);
      r.id  = id;
      r.uf  = (ea < 0);
      r.vis = 1'b0;
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.req0_valid = (src0.size() > 0);
      bus.req0_m     = (src0.size() > 0) ? 10'(src0[0].m)  : 10'd0;
      bus.req0_e     = (src0.size() > 0) ? 6'(src0[0].e)   : 6'd0;
      bus.req0_rnd   = (src0.size() > 0) ? 1'(src0[0].rnd) : 1'b0;
      bus.req1_valid = (src1.size() > 0);
      bus.req1_m     = (src1.size() > 0) ? 10'(src1[0].m)  : 10'd0;
      bus.req1_e     = (src1.size() > 0) ? 6'(src1[0].e)   : 6'd0;
      bus.req1_rnd   = (src1.size() > 0) ? 1'(src1[0].rnd) : 1'b0;
      bus.out_ready  = outReady;
   endtask

   task automatic runCycle();
      logic v0, v1, g, can, e0, e1;
      res_t d, t;
      op_t  o;
      drive();
      @(negedge clk);
      v0  = (src0.size() > 0);
      v1  = (src1.size() > 0);
      g   = (v0 && v1) ? prio : v1;
      can = rst && ((q.size() < 2) || outReady);
      e0  = can && !g;
      e1  = can && g;
      chk("req0_ready", bus.req0_ready, e0);
      chk("req1_ready", bus.req1_ready, e1);
      chk("busy", bus.busy, q.size() > 0);
      if (q.size() > 0 && q[0].vis) begin
         chk("out_valid", bus.out_valid, 1);
         chk("out_m", bus.out_m, q[0].m);
         chk("out_e", bus.out_e, q[0].e);
         chk("out_id", bus.out_id, q[0].id);
         chk("out_uf", bus.out_uf, q[0].uf);
      end else begin
         chk("out_valid", bus.out_valid, 0);
      end
      if (bus.out_valid && outReady) begin
         d.m = bus.out_m; d.e = bus.out_e; d.id = bus.out_id;
         d.uf = bus.out_uf; d.vis = 1'b1;
         dq.push_back(d);
      end
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
         accCnt++;
      @(posedge clk);
      if (!rst) begin
         q.delete();
         prio = 1'b0;
      end else begin
         if (q.size() > 0 && q[0].vis && outReady) void'(q.pop_front());
         if (q.size() > 0) begin
            t = q[0]; t.vis = 1'b1; q[0] = t;
         end
         if (v0 && e0) begin
            o = src0.pop_front();
            q.push_back(model(o, 1'b0));
            prio = 1'b1;
         end else if (v1 && e1) begin
            o = src1.pop_front();
            q.push_back(model(o, 1'b1));
            prio = 1'b0;
         end
      end
      #1;
      drive();
   endtask

   initial begin
      op_t o;
      drive();
      repeat (2) runCycle();
      rst = 1'b1;
      outReady = 1'b1;

      // Single op
      o = '{m: 'h155, e: 20, rnd: 0}; src0.push_back(o);
      repeat (4) runCycle();
      chk("single_cnt", dq.size(), 1);
      if (dq.size() > 0) begin
         chk("single_m", dq[0].m, 11'h155);
         chk("single_e", dq[0].e, 6'd5);
         chk("single_id", dq[0].id, 1'b0);
         chk("single_uf", dq[0].uf, 1'b0);
      end
      dq.delete();

      // Round carry
      o = '{m: 'h3FF, e: 20, rnd: 1}; src1.push_back(o);
      repeat (4) runCycle();
      chk("carry_cnt", dq.size(), 1);
      if (dq.size() > 0) begin
         chk("carry_m", dq[0].m, 11'h400);
         chk("carry_e", dq[0].e, 6'd6);
         chk("carry_id", dq[0].id, 1'b1);
      end
      dq.delete();

      // Underflow, then the carry boundary that just avoids it
      o = '{m: 'h001, e: 10, rnd: 1}; src0.push_back(o);
      repeat (4) runCycle();
      o = '{m: 'h3FF, e: 14, rnd: 1}; src1.push_back(o);
      repeat (4) runCycle();
      chk("uf_cnt", dq.size(), 2);
      if (dq.size() > 1) begin
         chk("uf_m", dq[0].m, 11'h002);
         chk("uf_e", dq[0].e, 6'h3B);
         chk("uf_flag", dq[0].uf, 1'b1);
         chk("edge_e", dq[1].e, 6'd0);
         chk("edge_uf", dq[1].uf, 1'b0);
      end
      dq.delete();

      // Round-robin with both requesters continuously valid
      for (int i = 0; i < 3; i++) begin
         o = '{m: 16 * i, e: 30 + i, rnd: i % 2};
         src0.push_back(o);
         src1.push_back(o);
      end
      accCnt = 0;
      repeat (6) runCycle();
      chk("rr_accepts", accCnt, 6);
      repeat (3) runCycle();
      chk("rr_cnt", dq.size(), 6);
      for (int i = 0; i < 6 && i < dq.size(); i++)
         chk("rr_id", dq[i].id, i % 2);
      dq.delete();

      // Backpressure: only two operands fit, then ready drops
      outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         o = '{m: 100 + i, e: 40 - i, rnd: 1}; src0.push_back(o);
         o = '{m: 200 + i, e: 50 - i, rnd: 0}; src1.push_back(o);
      end
      accCnt = 0;
      repeat (5) runCycle();
      chk("bp_accepts", accCnt, 2);
      outReady = 1'b1;
      repeat (10) runCycle();
      chk("bp_drain_cnt", dq.size(), 6);
      dq.delete();

      // Reset with both stages full
      outReady = 1'b0;
      o = '{m: 1, e: 20, rnd: 0}; src0.push_back(o);
      o = '{m: 2, e: 21, rnd: 0}; src0.push_back(o);
      repeat (3) runCycle();
      chk("pre_rst_busy", bus.busy, 1'b1);
      rst = 1'b0;
      runCycle();
      rst = 1'b1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      outReady = 1'b1;
      o = '{m: 5, e: 25, rnd: 0}; src0.push_back(o);
      o = '{m: 6, e: 26, rnd: 0}; src1.push_back(o);
      repeat (5) runCycle();
      chk("rst_cnt", dq.size(), 2);
      if (dq.size() > 0) chk("rst_first_id", dq[0].id, 1'b0);
      dq.delete();

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         if (src0.size() < 3 && $urandom_range(0, 1) == 1) begin
            o = '{m: int'($urandom_range(0, 1023)), e: int'($urandom_range(0, 63)),
                  rnd: int'($urandom_range(0, 1))};
            src0.push_back(o);
         end
         if (src1.size() < 3 && $urandom_range(0, 1) == 1) begin
            o = '{m: int'($urandom_range(0, 1023)), e: int'($urandom_range(0, 63)),
                  rnd: int'($urandom_range(0, 1))};
            src1.push_back(o);
         end
         outReady = ($urandom_range(0, 3) != 0);
         runCycle();
      end
      outReady = 1'b1;
      repeat (20) runCycle();
      chk("final_busy", bus.busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpmult_round_arbiter.md
Name: fpmult_round_arbiter

Overview:
- Two-requester arbiter and pipeline controller for one shared normalize/round stage of the FP multiplier.
- Two multiplier pipelines present a normalized mantissa, a biased-sum exponent and a round-up decision. The block grants one requester per cycle (round-robin), removes the bias, applies the increment and renormalizing exponent bump, and returns the result tagged with the requester id.
- It sits between the multiplier product/normalize stages and the final pack/flag stage.

Parameters:
- MANT_W, 10, stored mantissa width (`MANTISSA).
- EXP_W, 5, exponent width (`EXPONENT); exponent buses are EXP_W+1 bits.
- BIAS, 15, exponent bias subtracted from the normalized exponent.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand.
- req0_ready  out  1  requester 0 operand accepted this cycle (when valid).
- req0_m  in  MANT_W  requester 0 normalized mantissa.
- req0_e  in  EXP_W+1  requester 0 normalized exponent (biased sum).
- req0_rnd  in  1  requester 0 round-up decision.
- req1_valid, req1_ready, req1_m, req1_e, req1_rnd: same as requester 0, for requester 1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_m  out  MANT_W+1  rounded mantissa including carry bit.
- out_e  out  EXP_W+1  unbiased/adjusted exponent.
- out_id  out  1  requester that produced the result.
- out_uf  out  1  exponent underflow: adjusted exponent below zero before wrap.
- busy  out  1  any stage holds data.

Behaviour:
- Reset (rst=0 at a clock edge): s1_valid, s2_valid, out_valid, out_m, out_e, out_id, out_uf, busy and prio all clear to 0. In-flight operands are discarded. req*_ready is 0 while rst=0.
- Pipeline:
  - Stage S1 registers the granted operand and id.
  - Stage S2 is the output register.
  - Latency: operand accepted at edge k appears with out_valid=1 after edge k+1, i.e. visible in the cycle following edge k+1, two cycles after presentation.
  - Throughput: one result per cycle with no stalls.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - On s2_adv, S2 loads S1 contents and s2_valid := s1_valid.
  - On s1_adv, S1 loads the accepted operand; s1_valid := accept.
  - When stalled, both stages hold data unchanged.
- Arbitration:
  - grant = requester 0 if only req0_valid; requester 1 if only req1_valid; prio if both valid.
  - reqN_ready = rst && s1_adv && (grant==N). Ready is asserted only to the granted requester.
  - accept = reqN_valid && reqN_ready.
  - On accept, prio := ~grant. Otherwise prio holds.
  - Requesters hold valid and data stable until accepted. The grant therefore stays stable across stalls.
- Arithmetic (registered into S2, computed from S1):
  - RoundE = e - BIAS and RoundEP = e - BIAS + 1, both modulo 2^(EXP_W+1).
  - sum = {1'b0, m} + rnd, MANT_W+1 bits.
  - out_m = sum.
  - out_e = RoundEP if sum[MANT_W]=1 (carry on round-up), else RoundE.
  - out_uf = 1 when the unwrapped adjusted exponent is negative, i.e. e < BIAS without carry, or e < BIAS-1 with carry.
- out_m, out_e, out_id and out_uf are stable while out_valid=1 and out_ready=0.
- busy = s1_valid || s2_valid.
- Simultaneous events:
  - A new accept in the same cycle S1 drains into S2 is legal (full throughput).
  - out_ready=0 with both stages full drives both ready outputs to 0.
- Reset asserted mid-stall clears state regardless of out_ready.

Test Plan:
- Single op: rst released, req0 m=0x155 e=20 rnd=0, out_ready=1 -> req0_ready=1 first cycle; two cycles later out_valid=1, out_m=0x155, out_e=5, out_id=0, out_uf=0.
- Round carry: req1 m=0x3FF e=20 rnd=1 -> out_m=0x400, out_e=6, out_id=1.
- Underflow: req0 m=0x001 e=10 rnd=1 -> out_m=0x002, out_e=6'h3B, out_uf=1. Separately, e=14, m=0x3FF, rnd=1 -> out_e=0, out_uf=0.
- Round-robin: both valid continuously for 6 ops, out_ready=1 -> out_id sequence 0,1,0,1,0,1; one accept per cycle; no bubbles.
- Backpressure: hold out_ready=0 for 5 cycles with both requesters valid -> exactly two ops accepted, then req0_ready=req1_ready=0; outputs stable. On release, results drain in order with no loss or duplication.
- Reset mid-flight: two ops in S1/S2, rst=0 for one cycle -> out_valid=0, busy=0, prio=0. The next simultaneous request grants requester 0.
